// File: rtl/data_mem_responder.sv
// Word-organised data memory behind a valid/ready request/response handshake.
// Every access takes a fixed number of wait cycles, then the response is held until the initiator takes it.
module data_mem_responder #(
  parameter int XLEN            = 32,
  parameter int MEMORY_CAPACITY = 256,
  parameter int LATENCY         = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  input  logic [XLEN/8-1:0] req_be,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [XLEN-1:0]   resp_rdata,
  output logic              resp_err
);

  localparam int NB  = XLEN / 8;
  localparam int OFF = $clog2(NB);
  localparam int AW  = (MEMORY_CAPACITY > 1) ? $clog2(MEMORY_CAPACITY) : 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t            state;
  logic [3:0]        cnt;
  logic              lat_we;
  logic [31:0]       lat_addr;
  logic [XLEN-1:0]   lat_wdata;
  logic [NB-1:0]     lat_be;

  logic [XLEN-1:0]   mem [MEMORY_CAPACITY];

  logic [31:0]       word_idx;
  logic [AW-1:0]     mem_idx;
  logic              addr_err;
  logic              access;

  // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    word_idx = 32'd0;
    mem_idx  = '0;
    addr_err = 1'b0;
    access   = 1'b0;
    word_idx = lat_addr >> OFF;
    mem_idx  = word_idx[AW-1:0];
    addr_err = (lat_addr[OFF-1:0] != '0) || (word_idx >= 32'(MEMORY_CAPACITY));
    // The counter runs 0..LATENCY, so the access edge lands LATENCY+1 edges after acceptance.
    access   = (state == WAIT) && (cnt == 4'(LATENCY));
  end

  assign req_ready = (state == IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      lat_we     <= 1'b0;
      lat_addr   <= 32'd0;
      lat_wdata  <= '0;
      lat_be     <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            lat_we    <= req_we;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            lat_be    <= req_be;
            cnt       <= 4'd0;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (access) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= addr_err;
            resp_rdata <= (!lat_we && !addr_err) ? mem[mem_idx] : '0;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: the storage array has no reset; its contents survive reset and it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (access && lat_we && !addr_err) begin
      for (int i = 0; i < NB; i++) begin
        if (lat_be[i]) mem[mem_idx][8*i +: 8] <= lat_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: a LATENCY=2 instance for the main sequence and a
// LATENCY=1 instance for back-to-back traffic; expected responses are queued at stimulus time.
module tb_data_mem_responder;

  logic              clk = 1'b0;
  logic              reset;
  logic              req_we;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic [3:0]        req_be;
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [1:0]        resp_valid;
  logic [1:0]        resp_ready;
  logic [1:0]        resp_err;
  logic [1:0][31:0]  resp_rdata;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  data_mem_responder #(.XLEN(32), .MEMORY_CAPACITY(256), .LATENCY(2)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
  );

  data_mem_responder #(.XLEN(32), .MEMORY_CAPACITY(256), .LATENCY(1)) dut_l1 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after the accepting edge.
  task automatic start(input int s, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be);
    req_we       = we;
    req_addr     = addr;
    req_wdata    = wdata;
    req_be       = be;
    req_valid[s] = 1'b1;
    check("req_ready_idle", 64'(req_ready[s]), 64'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid[s] = 1'b0;
    req_we       = ~we;
    req_addr     = $urandom;
    req_wdata    = $urandom;
    req_be       = 4'($urandom);
  endtask

  task automatic finish_txn(input int s, input int lat, input bit hold);
    int   n = 0;
    exp_t e;
    check("resp_valid_early", 64'(resp_valid[s]), 64'd0);
    while (n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (resp_valid[s]) break;
    end
    check("resp_latency", 64'(n), 64'(lat + 1));
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_underflow: observed empty expected entry");
      return;
    end
    e = sb.pop_front();
    check("resp_rdata", 64'(resp_rdata[s]), 64'(e.rdata));
    check("resp_err", 64'(resp_err[s]), 64'(e.err));
    check("req_ready_busy", 64'(req_ready[s]), 64'd0);
    if (hold) begin
      for (int i = 0; i < 5; i++) begin
        req_valid[s] = 1'b1;
        req_we       = 1'b1;
        req_addr     = 32'h30;
        req_wdata    = 32'hBAD0BAD0;
        req_be       = 4'hF;
        @(posedge clk);
        @(negedge clk);
        check("hold_valid", 64'(resp_valid[s]), 64'd1);
        check("hold_rdata", 64'(resp_rdata[s]), 64'(e.rdata));
        check("hold_req_ready", 64'(req_ready[s]), 64'd0);
      end
      req_valid[s] = 1'b0;
    end
    resp_ready[s] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready[s] = 1'b0;
    check("resp_valid_cleared", 64'(resp_valid[s]), 64'd0);
    check("idle_after_resp", 64'(req_ready[s]), 64'd1);
  endtask

  task automatic txn(input int s, input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] be,
                     input logic [31:0] exp_rdata, input logic exp_err,
                     input int lat, input bit hold);
    exp_t e;
    e.rdata = exp_rdata;
    e.err   = exp_err;
    sb.push_back(e);
    start(s, we, addr, wdata, be);
    finish_txn(s, lat, hold);
  endtask

  // Reset lands while the response is being held; outputs must clear without a clock edge.
  task automatic reset_in_resp(input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [31:0] exp_rdata);
    start(0, we, addr, wdata, 4'hF);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_resp_valid_before", 64'(resp_valid[0]), 64'd1);
    check("rst_resp_rdata_before", 64'(resp_rdata[0]), 64'(exp_rdata));
    #2 reset = 1'b0;
    #1;
    check("rst_resp_valid_async", 64'(resp_valid[0]), 64'd0);
    check("rst_resp_rdata_async", 64'(resp_rdata[0]), 64'd0);
    check("rst_resp_ready_async", 64'(req_ready[0]), 64'd1);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    reset      = 1'b0;
    req_we     = 1'b0;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;
    req_be     = 4'd0;
    req_valid  = 2'b00;
    resp_ready = 2'b00;
    repeat (2) @(negedge clk);
    check("reset_req_ready", 64'(req_ready), 64'b11);
    check("reset_resp_valid", 64'(resp_valid), 64'b00);
    check("reset_resp_rdata", 64'(resp_rdata[0]), 64'd0);
    check("reset_resp_err", 64'(resp_err), 64'b00);
    reset = 1'b1;
    @(negedge clk);

    // Full store then readback, partial byte store, and an all-zero byte enable.
    txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0, 2, 1'b0);
    txn(0, 1'b0, 32'h10, 32'h0,        4'h0, 32'hDEADBEEF, 1'b0, 2, 1'b0);
    txn(0, 1'b1, 32'h10, 32'h000000AA, 4'h1, 32'h0, 1'b0, 2, 1'b0);
    txn(0, 1'b0, 32'h10, 32'h0,        4'h0, 32'hDEADBEAA, 1'b0, 2, 1'b0);
    txn(0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, 32'h0, 1'b0, 2, 1'b0);
    txn(0, 1'b0, 32'h10, 32'h0,        4'h0, 32'hDEADBEAA, 1'b0, 2, 1'b0);

    // Misaligned and out-of-range accesses must not touch memory.
    txn(0, 1'b1, 32'h00,  32'h0BADF00D, 4'hF, 32'h0, 1'b0, 2, 1'b0);
    txn(0, 1'b0, 32'h12,  32'h0,        4'h0, 32'h0, 1'b1, 2, 1'b0);
    txn(0, 1'b1, 32'h12,  32'h11111111, 4'hF, 32'h0, 1'b1, 2, 1'b0);
    txn(0, 1'b0, 32'h400, 32'h0,        4'h0, 32'h0, 1'b1, 2, 1'b0);
    txn(0, 1'b1, 32'h400, 32'h22222222, 4'hF, 32'h0, 1'b1, 2, 1'b0);
    txn(0, 1'b0, 32'h00,  32'h0,        4'h0, 32'h0BADF00D, 1'b0, 2, 1'b0);
    txn(0, 1'b0, 32'h10,  32'h0,        4'h0, 32'hDEADBEAA, 1'b0, 2, 1'b0);

    // Response stalled for five cycles while an ignored store to the same word is offered.
    txn(0, 1'b1, 32'h30, 32'h13572468, 4'hF, 32'h0, 1'b0, 2, 1'b0);
    txn(0, 1'b0, 32'h30, 32'h0,        4'h0, 32'h13572468, 1'b0, 2, 1'b1);
    txn(0, 1'b0, 32'h30, 32'h0,        4'h0, 32'h13572468, 1'b0, 2, 1'b0);

    // Reset mid-WAIT drops the pending store.
    txn(0, 1'b1, 32'h20, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0, 2, 1'b0);
    start(0, 1'b1, 32'h20, 32'h12345678, 4'hF);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("rst_wait_req_ready", 64'(req_ready[0]), 64'd1);
    check("rst_wait_resp_valid", 64'(resp_valid[0]), 64'd0);
    check("rst_wait_resp_rdata", 64'(resp_rdata[0]), 64'd0);
    check("rst_wait_resp_err", 64'(resp_err[0]), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    txn(0, 1'b0, 32'h20, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0, 2, 1'b0);

    // Reset in RESP discards the response; a committed store persists.
    reset_in_resp(1'b0, 32'h10, 32'h0, 32'hDEADBEAA);
    reset_in_resp(1'b1, 32'h24, 32'h55AA55AA, 32'h0);
    txn(0, 1'b0, 32'h24, 32'h0, 4'h0, 32'h55AA55AA, 1'b0, 2, 1'b0);

    // LATENCY=1 instance, back-to-back transactions.
    txn(1, 1'b1, 32'h40, 32'h01020304, 4'hF, 32'h0, 1'b0, 1, 1'b0);
    txn(1, 1'b0, 32'h40, 32'h0,        4'h0, 32'h01020304, 1'b0, 1, 1'b0);
    txn(1, 1'b1, 32'h44, 32'hFFFF0000, 4'hF, 32'h0, 1'b0, 1, 1'b0);
    txn(1, 1'b0, 32'h44, 32'h0,        4'h0, 32'hFFFF0000, 1'b0, 1, 1'b0);
    txn(1, 1'b0, 32'h41, 32'h0,        4'h0, 32'h0, 1'b1, 1, 1'b0);

    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
